// File: rtl/mdio_master_if.sv
// Requester-side command interface of the MDIO master: start/busy/done handshake,
// command fields, and read results.
interface mdio_master_if;
  logic        start;
  logic        rw;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        rd_err;

  // Requester that issues commands
  modport master (
    output start, rw, phy_addr, reg_addr, wdata,
    input  busy, done, rdata, rd_err
  );

  // MDIO master block that serves them
  modport slave (
    input  start, rw, phy_addr, reg_addr, wdata,
    output busy, done, rdata, rd_err
  );
endinterface

// File: rtl/mdio_master.sv
// Clause 22 MDIO/MDC master: runs single register read/write frames, generates MDC,
// and returns read data with a turnaround error flag.
module mdio_master #(
  parameter int unsigned DIV_HALF     = 10,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  localparam int unsigned PhW = $clog2(2 * DIV_HALF);
  localparam logic [PhW-1:0] PhRise = PhW'(DIV_HALF - 1);
  localparam logic [PhW-1:0] PhEnd  = PhW'(2 * DIV_HALF - 1);

  typedef enum logic [2:0] {StIdle, StPre, StCmd, StTa, StData, StDone} state_e;

  state_e         state_q, state_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic [5:0]     cnt_q, cnt_d;       // bits left in the current state, minus one
  logic [31:0]    tx_q, tx_d;         // ST..DATA, MSB is the bit on the wire
  logic [15:0]    rx_q, rx_d;
  logic           is_read_q, is_read_d;
  logic           ta_err_q, ta_err_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           rd_err_q, rd_err_d;
  logic           mdc_q, mdc_d;
  logic           o_q, o_d;
  logic           oe_q, oe_d;
  logic [31:0]    tx_shift;
  logic           nxt_bit;
  logic           nxt_oe;

  // State and registered pad outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      is_read_q <= 1'b0;
      ta_err_q  <= 1'b0;
      rdata_q   <= '0;
      rd_err_q  <= 1'b0;
      mdc_q     <= 1'b0;
      o_q       <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      is_read_q <= is_read_d;
      ta_err_q  <= ta_err_d;
      rdata_q   <= rdata_d;
      rd_err_q  <= rd_err_d;
      mdc_q     <= mdc_d;
      o_q       <= o_d;
      oe_q      <= oe_d;
    end
  end

  // Next-state: bit sequencing, MDC phase, sampling and result update
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    is_read_d = is_read_q;
    ta_err_d  = ta_err_q;
    rdata_d   = rdata_q;
    rd_err_d  = rd_err_q;
    mdc_d     = mdc_q;
    o_d       = o_q;
    oe_d      = oe_q;
    tx_shift  = {tx_q[30:0], 1'b0};
    nxt_bit   = 1'b1;
    nxt_oe    = 1'b0;
    unique case (state_q)
      StIdle: begin
        mdc_d   = 1'b0;
        o_d     = 1'b1;
        oe_d    = 1'b0;
        phase_d = '0;
        if (bus.start) begin
          is_read_d = bus.rw;
          ta_err_d  = 1'b0;
          tx_d      = {2'b01, bus.rw ? 2'b10 : 2'b01, bus.phy_addr, bus.reg_addr, 2'b10,
                       bus.wdata};
          oe_d      = 1'b1;
          if (PREAMBLE_LEN != 0) begin
            state_d = StPre;
            cnt_d   = 6'(PREAMBLE_LEN - 1);
            o_d     = 1'b1;
          end else begin
            state_d = StCmd;
            cnt_d   = 6'd13;
            o_d     = 1'b0;  // first ST bit
          end
        end
      end
      StPre, StCmd, StTa, StData: begin
        phase_d = phase_q + PhW'(1);
        if (phase_q == PhRise) begin
          mdc_d = 1'b1;
          if (state_q == StTa && cnt_q == 6'd0) ta_err_d = mdio_i;
          if (state_q == StData) rx_d = {rx_q[14:0], mdio_i};
        end
        if (phase_q == PhEnd) begin
          phase_d = '0;
          mdc_d   = 1'b0;
          if (state_q != StPre) tx_d = tx_shift;
          if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
          end else begin
            case (state_q)
              StPre:   begin state_d = StCmd;  cnt_d = 6'd13; end
              StCmd:   begin state_d = StTa;   cnt_d = 6'd1;  end
              StTa:    begin state_d = StData; cnt_d = 6'd15; end
              default: state_d = StDone;
            endcase
          end
          // Preamble does not shift tx, so its last bit hands over tx_q[31] unshifted
          nxt_bit = (state_q == StPre) ? ((cnt_q != 6'd0) ? 1'b1 : tx_q[31]) : tx_shift[31];
          nxt_oe  = (state_d == StPre) || (state_d == StCmd) ||
                    (((state_d == StTa) || (state_d == StData)) && !is_read_q);
          oe_d    = nxt_oe;
          o_d     = nxt_oe ? nxt_bit : 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (is_read_q) begin
          rdata_d  = rx_q;
          rd_err_d = ta_err_q;
        end else begin
          rd_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy   = (state_q == StPre) || (state_q == StCmd) ||
                      (state_q == StTa) || (state_q == StData);
  assign bus.done   = (state_q == StDone);
  assign bus.rdata  = rdata_q;
  assign bus.rd_err = rd_err_q;
  assign mdc        = mdc_q;
  assign mdio_o     = o_q;
  assign mdio_oe    = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: table of read/write commands against a PHY model,
// plus start-hammering, mid-frame reset and a short-preamble/fast-MDC instance.
module tb_mdio_master;

  logic clk;
  logic rst;
  int   cyc;

  mdio_master_if bus_a ();
  mdio_master_if bus_b ();

  logic mdc_a, o_a, oe_a, i_a;
  logic mdc_b, o_b, oe_b, i_b;

  assign i_b = 1'b1;

  mdio_master #(.DIV_HALF(10), .PREAMBLE_LEN(32)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_a),
    .mdc     (mdc_a),
    .mdio_o  (o_a),
    .mdio_oe (oe_a),
    .mdio_i  (i_a)
  );

  mdio_master #(.DIV_HALF(2), .PREAMBLE_LEN(0)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_b),
    .mdc     (mdc_b),
    .mdio_o  (o_b),
    .mdio_oe (oe_b),
    .mdio_i  (i_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: record mdio_o/oe at every MDC rising edge of the current frame
  int          rises_a;
  logic [63:0] cap_o, cap_oe;
  logic        mdc_prev_a, busy_prev_a;
  initial begin
    rises_a = 0; mdc_prev_a = 1'b0; busy_prev_a = 1'b0; cap_o = '0; cap_oe = '0;
  end
  always @(negedge clk) begin
    if (bus_a.busy && !busy_prev_a) rises_a = 0;
    if (mdc_a && !mdc_prev_a) begin
      if (rises_a < 64) begin
        cap_o[63 - rises_a]  = o_a;
        cap_oe[63 - rises_a] = oe_a;
      end
      rises_a++;
    end
    mdc_prev_a  = mdc_a;
    busy_prev_a = bus_a.busy;
  end

  // PHY model: bit k of the frame is read at rising edge k; TA2 is k=47, data k=48..63
  logic        absent, ta2;
  logic [15:0] pdata;
  always_comb begin
    if (absent || rises_a < 47 || rises_a > 63) i_a = 1'b1;
    else if (rises_a == 47)                     i_a = ta2;
    else                                        i_a = pdata[4'(63 - rises_a)];
  end

  // Monitor B: post-preamble frame bits and MDC period
  int          rises_b, t_first, t_second;
  logic [31:0] cap_b;
  logic        mdc_prev_b, busy_prev_b;
  initial begin
    rises_b = 0; mdc_prev_b = 1'b0; busy_prev_b = 1'b0; cap_b = '0; t_first = 0; t_second = 0;
  end
  always @(negedge clk) begin
    if (bus_b.busy && !busy_prev_b) rises_b = 0;
    if (mdc_b && !mdc_prev_b) begin
      if (rises_b < 32) cap_b[31 - rises_b] = o_b;
      if (rises_b == 0) t_first = cyc;
      if (rises_b == 1) t_second = cyc;
      rises_b++;
    end
    mdc_prev_b  = mdc_b;
    busy_prev_b = bus_b.busy;
  end

  typedef struct {
    logic        rw;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic        absent;
    logic        ta2;
    logic [15:0] pdata;
    logic [31:0] exp_frame;
    logic [31:0] exp_oe;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_a(input vec_t v);
    bus_a.rw       = v.rw;
    bus_a.phy_addr = v.phy;
    bus_a.reg_addr = v.rg;
    bus_a.wdata    = v.wdata;
    absent         = v.absent;
    ta2            = v.ta2;
    pdata          = v.pdata;
  endtask

  task automatic run_a(input vec_t v, input string tag);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    drive_a(v);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    for (int c = 1; c <= 1400; c++) begin
      @(negedge clk);
      if (bus_a.busy) busy_cnt++;
      if (bus_a.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    check({tag, " busy_len"}, busy_cnt, 1280);
    check({tag, " done_at"}, done_at, 1281);
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " rdata"}, bus_a.rdata, v.exp_rdata);
    check({tag, " rd_err"}, bus_a.rd_err, v.exp_err);
    check({tag, " preamble"}, cap_o[63:32], 32'hFFFF_FFFF);
    check({tag, " frame"}, cap_o[31:0], v.exp_frame);
    check({tag, " oe"}, cap_oe, {32'hFFFF_FFFF, v.exp_oe});
    check({tag, " mdc_rises"}, rises_a, 64);
  endtask

  task automatic run_b(input logic rw, input logic [4:0] rg, input logic [31:0] exp_frame,
                       input logic [15:0] exp_rdata, input logic exp_err, input string tag);
    int busy_cnt, done_at;
    busy_cnt = 0; done_at = -1;
    @(negedge clk);
    bus_b.rw       = rw;
    bus_b.phy_addr = 5'd1;
    bus_b.reg_addr = rg;
    bus_b.wdata    = 16'h3100;
    bus_b.start    = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus_b.busy) busy_cnt++;
      if (bus_b.done && done_at < 0) done_at = c;
    end
    check({tag, " busy_len"}, busy_cnt, 128);
    check({tag, " done_at"}, done_at, 129);
    check({tag, " frame"}, cap_b, exp_frame);
    check({tag, " mdc_rises"}, rises_b, 32);
    check({tag, " mdc_period"}, t_second - t_first, 4);
    check({tag, " rdata"}, bus_b.rdata, exp_rdata);
    check({tag, " rd_err"}, bus_b.rd_err, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nbusy, ndone, d1, d2, busy_seen;
    logic b1282, b1283, bprev;

    vecs[0] = '{1'b0, 5'd1,  5'd0,  16'h3100, 1'b0, 1'b0, 16'h0000,
                32'h5082_3100, 32'hFFFF_FFFF, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 5'd1,  5'd1,  16'h0000, 1'b0, 1'b0, 16'h786D,
                32'h6087_FFFF, 32'hFFFC_0000, 16'h786D, 1'b0};
    vecs[2] = '{1'b1, 5'd1,  5'd1,  16'h0000, 1'b1, 1'b0, 16'h0000,
                32'h6087_FFFF, 32'hFFFC_0000, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b0, 5'd1,  5'd0,  16'h3100, 1'b0, 1'b0, 16'h0000,
                32'h5082_3100, 32'hFFFF_FFFF, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b1, 5'd31, 5'd31, 16'h0000, 1'b0, 1'b1, 16'h0001,
                32'h6FFF_FFFF, 32'hFFFC_0000, 16'h0001, 1'b1};
    vecs[5] = '{1'b0, 5'd21, 5'd10, 16'hA5C3, 1'b0, 1'b0, 16'h0000,
                32'h5AAA_A5C3, 32'hFFFF_FFFF, 16'h0001, 1'b0};

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.rw = 1'b0; bus_a.phy_addr = '0; bus_a.reg_addr = '0;
    bus_a.wdata = '0;
    bus_b.start = 1'b0; bus_b.rw = 1'b0; bus_b.phy_addr = '0; bus_b.reg_addr = '0;
    bus_b.wdata = '0;
    absent = 1'b0; ta2 = 1'b0; pdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("reset busy", bus_a.busy, 0);
    check("reset done", bus_a.done, 0);
    check("reset rdata", bus_a.rdata, 0);
    check("reset rd_err", bus_a.rd_err, 0);
    check("reset mdc", mdc_a, 0);
    check("reset mdio_o", o_a, 1);
    check("reset mdio_oe", oe_a, 0);

    for (int i = 0; i < 6; i++) run_a(vecs[i], $sformatf("vec%0d", i));

    // start held high through a whole frame: one frame, then the next one right after done
    nbusy = 0; ndone = 0; d1 = -1; d2 = -1; b1282 = 1'bx; b1283 = 1'bx; bprev = 1'b0;
    @(negedge clk);
    drive_a(vecs[0]);
    bus_a.start = 1'b1;
    for (int c = 1; c <= 2700; c++) begin
      @(negedge clk);
      if (bus_a.busy && !bprev) nbusy++;
      bprev = bus_a.busy;
      if (bus_a.done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        else if (ndone == 2) d2 = c;
      end
      if (c == 1282) b1282 = bus_a.busy;
      if (c == 1283) begin
        b1283 = bus_a.busy;
        bus_a.start = 1'b0;
      end
    end
    check("hold first_done", d1, 1281);
    check("hold idle_after_done", b1282, 0);
    check("hold next_accept", b1283, 1);
    check("hold second_done", d2, 2563);
    check("hold done_cnt", ndone, 2);
    check("hold frame_cnt", nbusy, 2);

    // reset in the middle of a write frame
    @(negedge clk);
    drive_a(vecs[0]);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    repeat (600) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst mdc", mdc_a, 0);
    check("midrst mdio_oe", oe_a, 0);
    check("midrst mdio_o", o_a, 1);
    check("midrst busy", bus_a.busy, 0);
    check("midrst rdata", bus_a.rdata, 0);
    rst = 1'b0;
    ndone = 0; busy_seen = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (bus_a.done) ndone++;
      if (bus_a.busy) busy_seen++;
    end
    check("midrst no_done", ndone, 0);
    check("midrst stays_idle", busy_seen, 0);
    run_a(vecs[1], "after_rst");

    // no preamble, MDC = clk/4
    run_b(1'b0, 5'd0, 32'h5082_3100, 16'h0000, 1'b0, "short_wr");
    run_b(1'b1, 5'd1, 32'h6087_FFFF, 16'hFFFF, 1'b1, "short_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
